// File: rtl/instr_register_pipe_if.sv
// Handshake bundle for instr_register_pipe: write request,
// registered read port and divider busy flag.
interface instr_register_pipe_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int RESULT_W = 2*DATA_W
);
  logic                wr_valid;
  logic                wr_ready;
  logic [2:0]          wr_opcode;
  logic [DATA_W-1:0]   wr_operand_a;
  logic [DATA_W-1:0]   wr_operand_b;
  logic [ADDR_W-1:0]   wr_pointer;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_pointer;
  logic                rd_valid;
  logic [2:0]          rd_opcode;
  logic [DATA_W-1:0]   rd_operand_a;
  logic [DATA_W-1:0]   rd_operand_b;
  logic [RESULT_W-1:0] rd_result;
  logic [1:0]          rd_status;
  logic                busy;

  modport slave (
    input  wr_valid, wr_opcode,
    input  wr_operand_a, wr_operand_b,
    input  wr_pointer, rd_en, rd_pointer,
    output wr_ready, rd_valid, rd_opcode,
    output rd_operand_a, rd_operand_b,
    output rd_result, rd_status, busy
  );

  modport master (
    output wr_valid, wr_opcode,
    output wr_operand_a, wr_operand_b,
    output wr_pointer, rd_en, rd_pointer,
    input  wr_ready, rd_valid, rd_opcode,
    input  rd_operand_a, rd_operand_b,
    input  rd_result, rd_status, busy
  );
endinterface

// File: rtl/instr_register_pipe.sv
// Handshaked instruction register with iterative radix-2 divider.
// Define IR_STATUS_EN to store per-entry div-by-zero/carry status.
module instr_register_pipe #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int RESULT_W = 2*DATA_W
) (
  input logic                  clk,
  input logic                  reset_n,
  instr_register_pipe_if.slave bus
);
  localparam logic [2:0] OP_PASSA = 3'd1;
  localparam logic [2:0] OP_PASSB = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_MULT  = 3'd5;
  localparam logic [2:0] OP_DIV   = 3'd6;
  localparam logic [2:0] OP_MOD   = 3'd7;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_DIV  = 1'b1;

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DATA_W+1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W-1);
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  typedef struct packed {
    logic [2:0]          op;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic [RESULT_W-1:0] res;
  } entry_t;

  entry_t              mem_q [DEPTH];
  entry_t              rd_q;
  logic                rd_valid_q;
  logic [0:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W:0]     rem_q, rem_d, shl;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   da_q, db_q;
  logic [2:0]          dop_q;
  logic [ADDR_W-1:0]   dptr_q;

  logic                accept, is_div, div_done;
  logic [RESULT_W-1:0] ax, bx, alu;
  logic                we, we_ok, rd_ok;
  logic [ADDR_W-1:0]   wptr;
  entry_t              went;

  assign accept   = bus.wr_valid && bus.wr_ready;
  assign is_div   = (bus.wr_opcode == OP_DIV) ||
                    (bus.wr_opcode == OP_MOD);
  assign div_done = (state_q == S_DIV) && (cnt_q == LAST);

  assign bus.wr_ready = (state_q == S_IDLE) && reset_n;
  assign bus.busy     = (state_q == S_DIV);

  assign ax = RESULT_W'(bus.wr_operand_a);
  assign bx = RESULT_W'(bus.wr_operand_b);

  always_comb begin
    alu = '0;
    unique case (bus.wr_opcode)
      OP_PASSA: alu = ax;
      OP_PASSB: alu = bx;
      OP_ADD:   alu = ax + bx;
      OP_SUB:   alu = ax - bx;
      OP_MULT:  alu = ax * bx;
      default:  alu = '0;
    endcase
  end

  // Restoring step: shift in next dividend bit, subtract if it fits.
  always_comb begin
    shl   = {rem_q[DATA_W-1:0], quo_q[DATA_W-1]};
    rem_d = shl;
    quo_d = {quo_q[DATA_W-2:0], 1'b0};
    if (shl >= {1'b0, db_q}) begin
      rem_d    = shl - {1'b0, db_q};
      quo_d[0] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && is_div) begin
          state_d = S_DIV;
          cnt_d   = '0;
        end
      end
      S_DIV: begin
        cnt_d = cnt_q + CW'(1);
        if (div_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      da_q    <= '0;
      db_q    <= '0;
      dop_q   <= '0;
      dptr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept && is_div) begin
        rem_q  <= '0;
        quo_q  <= bus.wr_operand_a;
        da_q   <= bus.wr_operand_a;
        db_q   <= bus.wr_operand_b;
        dop_q  <= bus.wr_opcode;
        dptr_q <= bus.wr_pointer;
      end else if (state_q == S_DIV) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
      end
    end
  end

  always_comb begin
    we   = 1'b0;
    wptr = bus.wr_pointer;
    went = '0;
    unique case (1'b1)
      div_done: begin
        we      = 1'b1;
        wptr    = dptr_q;
        went.op = dop_q;
        went.a  = da_q;
        went.b  = db_q;
        went.res = (dop_q == OP_DIV) ?
                   RESULT_W'(quo_d) :
                   RESULT_W'(rem_d[DATA_W-1:0]);
      end
      (accept && !is_div): begin
        we       = 1'b1;
        went.op  = bus.wr_opcode;
        went.a   = bus.wr_operand_a;
        went.b   = bus.wr_operand_b;
        went.res = alu;
      end
      default: ;
    endcase
  end

  assign we_ok = we && ({1'b0, wptr} < DEPTH_L);
  assign rd_ok = {1'b0, bus.rd_pointer} < DEPTH_L;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_ok) begin
      mem_q[wptr[IW-1:0]] <= went;
    end
  end

  // Flop array read: same-edge writes are not yet visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_q       <= '0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en)
        rd_q <= rd_ok ? mem_q[bus.rd_pointer[IW-1:0]] : '0;
    end
  end

  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_opcode    = rd_q.op;
  assign bus.rd_operand_a = rd_q.a;
  assign bus.rd_operand_b = rd_q.b;
  assign bus.rd_result    = rd_q.res;

`ifdef IR_STATUS_EN
  logic [1:0]      wst;
  logic [1:0]      st_q [DEPTH];
  logic [1:0]      rd_st_q;
  logic [DATA_W:0] sum;

  always_comb begin
    sum = {1'b0, bus.wr_operand_a} +
          {1'b0, bus.wr_operand_b};
    wst = '0;
    if (div_done)
      wst[0] = (db_q == '0);
    else if (bus.wr_opcode == OP_ADD)
      wst[1] = sum[DATA_W];
    else if (bus.wr_opcode == OP_SUB)
      wst[1] = bus.wr_operand_a < bus.wr_operand_b;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) st_q[i] <= '0;
      rd_st_q <= '0;
    end else begin
      if (we_ok) st_q[wptr[IW-1:0]] <= wst;
      if (bus.rd_en)
        rd_st_q <= rd_ok ? st_q[bus.rd_pointer[IW-1:0]] : '0;
    end
  end

  assign bus.rd_status = rd_st_q;
`else
  assign bus.rd_status = 2'b00;
`endif
endmodule
